apb_master_mc: RTL and testbench

Parametrised, multi-slave APB (AMBA APB4) master.
- Accepts single read/write requests from a system-side valid/ready channel and runs the standard IDLE/SETUP/ACCESS protocol.
- Decodes the target slave from address bits and drives one-hot PSEL.
- Returns read data, slave error, and a timeout/decode-error response on a response channel.
- Sits between the system interconnect and a bank of APB peripherals; adds PSTRB, PPROT, PRDATA muxing, back-to-back transfers and a watchdog.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_slv_decode.sv | 53 +++++
 rtl/apb_master_mc.sv | 203 ++++++++++++++++++++
 tb/tb_apb_master_mc.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the multi-slave APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DECERR = 2'd3
  } apb_state_e;

  localparam int unsigned PPROT_PRIV   = 0;
  localparam int unsigned PPROT_NONSEC = 1;
  localparam int unsigned PPROT_INSTR  = 2;

  // Width of the slave-index field; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned num_slv);
    int unsigned w;
    w = (num_slv <= 1) ? 1 : $clog2(num_slv);
    return w;
  endfunction

endpackage

// File: rtl/apb_slv_decode.sv
// Slave index extraction, one-hot select for new requests, and response mux
// for the transfer currently on the bus (indexed by the registered PADDR).
module apb_slv_decode
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 12
) (
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [ADDR_W-1:0]         cur_addr,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr,
  output logic                      req_hit_c,
  output logic [NUM_SLV-1:0]        req_sel_c,
  output logic [DATA_W-1:0]         cur_rdata_c,
  output logic                      cur_ready_c,
  output logic                      cur_slverr_c
);

  localparam int unsigned SEL_W = sel_w(NUM_SLV);

  logic [SEL_W-1:0] req_idx;
  logic [SEL_W-1:0] cur_idx;
  logic             unused_addr_c;

  assign req_idx   = req_addr[SEL_LSB +: SEL_W];
  assign cur_idx   = cur_addr[SEL_LSB +: SEL_W];
  assign req_hit_c = 32'(req_idx) < NUM_SLV;

  // Only the index field matters here; the rest of the address is ignored.
  assign unused_addr_c = ^{req_addr, cur_addr};

  always_comb begin
    req_sel_c    = '0;
    cur_rdata_c  = '0;
    cur_ready_c  = 1'b0;
    cur_slverr_c = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (req_idx == SEL_W'(i)) begin
        req_sel_c[i] = 1'b1;
      end
      if (cur_idx == SEL_W'(i)) begin
        cur_rdata_c  = prdata[i*DATA_W +: DATA_W];
        cur_ready_c  = pready[i];
        cur_slverr_c = pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master_mc.sv
// APB4 master: system valid/ready request in, one-hot multi-slave APB out,
// single-cycle response pulse with slave, decode and watchdog errors.
module apb_master_mc
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_strb,
  input  logic [2:0]                req_prot,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [DATA_W/8-1:0]       PSTRB,
  output logic [2:0]                PPROT,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned CNT_W   = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
  localparam bit          WDOG_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e          state_q, state_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;

  logic                hit_c;
  logic [NUM_SLV-1:0]  req_sel_c;
  logic [DATA_W-1:0]   cur_rdata_c;
  logic                cur_ready_c;
  logic                cur_slverr_c;
  logic                accept_c;
  logic                wdog_exp_c;

  apb_slv_decode #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_SLV (NUM_SLV),
    .SEL_LSB (SEL_LSB)
  ) u_dec (
    .req_addr     (req_addr),
    .cur_addr     (paddr_q),
    .prdata       (PRDATA),
    .pready       (PREADY),
    .pslverr      (PSLVERR),
    .req_hit_c    (hit_c),
    .req_sel_c    (req_sel_c),
    .cur_rdata_c  (cur_rdata_c),
    .cur_ready_c  (cur_ready_c),
    .cur_slverr_c (cur_slverr_c)
  );

  // Ready in IDLE and in the completion cycle, which enables back-to-back.
  assign req_ready  = PRESETn &
                      ((state_q == ST_IDLE) | ((state_q == ST_ACCESS) & cur_ready_c));
  assign accept_c   = req_valid & req_ready;
  assign wdog_exp_c = WDOG_EN && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    wdog_d        = wdog_q;

    unique case (state_q)
      ST_IDLE: begin
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wdog_d    = '0;
      end
      ST_ACCESS: begin
        if (cur_ready_c) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = cur_slverr_c;
          rsp_rdata_d = (!pwrite_q && !cur_slverr_c) ? cur_rdata_c : '0;
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          pstrb_d     = '0;
        end else if (wdog_exp_c) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
          psel_d        = '0;
          penable_d     = 1'b0;
          pstrb_d       = '0;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      ST_DECERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request overrides the return to IDLE on the same edge.
    if (accept_c) begin
      state_d   = hit_c ? ST_SETUP : ST_DECERR;
      psel_d    = hit_c ? req_sel_c : '0;
      penable_d = 1'b0;
      pwrite_d  = req_write;
      paddr_d   = req_addr;
      pprot_d   = req_prot;
      if (req_write) begin
        pwdata_d = req_wdata;
        pstrb_d  = req_strb;
      end else begin
        pstrb_d  = '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wdog_q        <= wdog_d;
    end
  end

  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Directed bench for apb_master_mc: vector table plus hand-written sequences
// for back-to-back, decode error, watchdog and mid-transfer reset.
`timescale 1ns/1ps
module tb_apb_master_mc;
  import apb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid, req_valid3, req_ready, req_ready3, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [NS-1:0] psel;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0] pready, pslverr;

  logic          rsp_valid3, rsp_err3, rsp_timeout3, penable3, pwrite3;
  logic [DW-1:0] rsp_rdata3, pwdata3;
  logic [2:0]    psel3, pprot3;
  logic [AW-1:0] paddr3;
  logic [SW-1:0] pstrb3;
  logic          unused_dut3;
  assign unused_dut3 = ^{pwrite3, paddr3, pwdata3, pprot3};

  apb_master_mc #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(4), .SEL_LSB(12), .TIMEOUT(16)) dut (
    .PCLK(clk), .PRESETn(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  apb_master_mc #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(3), .SEL_LSB(12), .TIMEOUT(16)) dut3 (
    .PCLK(clk), .PRESETn(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .rsp_timeout(rsp_timeout3), .PSEL(psel3), .PENABLE(penable3), .PWRITE(pwrite3),
    .PADDR(paddr3), .PWDATA(pwdata3), .PSTRB(pstrb3), .PPROT(pprot3),
    .PRDATA(prdata[3*DW-1:0]), .PREADY(pready[2:0]), .PSLVERR(pslverr[2:0])
  );

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            wait_n;
    logic          slverr;
    logic [DW-1:0] rdata;
    logic [NS-1:0] exp_psel;
    logic [SW-1:0] exp_pstrb;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  int n_cmp = 0;
  int n_mis = 0;
  logic [DW-1:0] exp_pwdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    pready  = '1;
    pslverr = '1;
    for (int i = 0; i < int'(NS); i++) prdata[i*DW +: DW] = 32'hBAD0_0000 | 32'(i);
  endtask

  task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [2:0] p);
    req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
    req_valid = 1'b1;
  endtask

  // One complete transfer from IDLE with a scripted slave response.
  task automatic run_vec(input vec_t v, input int n);
    int idx;
    idx = int'(v.addr[13:12]);
    drive_req(v.write, v.addr, v.wdata, v.strb, v.prot);
    #1;
    chk($sformatf("v%0d ready_idle", n), 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    if (v.write) exp_pwdata = v.wdata;
    chk($sformatf("v%0d setup_psel", n), 64'(psel), 64'(v.exp_psel));
    chk($sformatf("v%0d setup_penable", n), 64'(penable), 64'd0);
    chk($sformatf("v%0d setup_paddr", n), 64'(paddr), 64'(v.addr));
    chk($sformatf("v%0d setup_pwrite", n), 64'(pwrite), 64'(v.write));
    chk($sformatf("v%0d setup_pstrb", n), 64'(pstrb), 64'(v.exp_pstrb));
    chk($sformatf("v%0d setup_pprot", n), 64'(pprot), 64'(v.prot));
    chk($sformatf("v%0d setup_pwdata", n), 64'(pwdata), 64'(exp_pwdata));
    step();
    for (int k = 0; k < v.wait_n; k++) begin
      pready[idx] = 1'b0;
      #1;
      chk($sformatf("v%0d wait%0d_penable", n, k), 64'(penable), 64'd1);
      chk($sformatf("v%0d wait%0d_psel", n, k), 64'(psel), 64'(v.exp_psel));
      chk($sformatf("v%0d wait%0d_rsp", n, k), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d wait%0d_ready", n, k), 64'(req_ready), 64'd0);
      step();
    end
    pready[idx] = 1'b1;
    pslverr[idx] = v.slverr;
    prdata[idx*DW +: DW] = v.rdata;
    #1;
    chk($sformatf("v%0d cpl_penable", n), 64'(penable), 64'd1);
    chk($sformatf("v%0d cpl_ready", n), 64'(req_ready), 64'd1);
    step();
    chk($sformatf("v%0d rsp_valid", n), 64'(rsp_valid), 64'd1);
    chk($sformatf("v%0d rsp_err", n), 64'(rsp_err), 64'(v.exp_err));
    chk($sformatf("v%0d rsp_rdata", n), 64'(rsp_rdata), 64'(v.exp_rdata));
    chk($sformatf("v%0d rsp_timeout", n), 64'(rsp_timeout), 64'd0);
    chk($sformatf("v%0d idle_psel", n), 64'(psel), 64'd0);
    chk($sformatf("v%0d idle_penable", n), 64'(penable), 64'd0);
    chk($sformatf("v%0d idle_pstrb", n), 64'(pstrb), 64'd0);
    chk($sformatf("v%0d idle_paddr", n), 64'(paddr), 64'(v.addr));
    bus_idle();
    step();
    chk($sformatf("v%0d rsp_pulse_end", n), 64'(rsp_valid), 64'd0);
  endtask

  // Slave 1 stalls; optionally answers in the 16th ACCESS cycle.
  task automatic run_timeout(input logic late_ready, input string tag);
    pready[1] = 1'b0;
    drive_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000);
    step();
    req_valid = 1'b0;
    step();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16 && late_ready) begin
        pready[1] = 1'b1;
        pslverr[1] = 1'b0;
        prdata[1*DW +: DW] = 32'h600D_600D;
      end
      #1;
      if (k == 1 || k == 15 || k == 16) begin
        chk($sformatf("%s acc%0d_penable", tag, k), 64'(penable), 64'd1);
        chk($sformatf("%s acc%0d_rsp", tag, k), 64'(rsp_valid), 64'd0);
        chk($sformatf("%s acc%0d_ready", tag, k), 64'(req_ready), 64'(k == 16 && late_ready));
      end
      step();
    end
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(!late_ready));
    chk({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(!late_ready));
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata), late_ready ? 64'h600D_600D : 64'd0);
    chk({tag, " psel"}, 64'(psel), 64'd0);
    chk({tag, " penable"}, 64'(penable), 64'd0);
    bus_idle();
    step();
    chk({tag, " rsp_end"}, 64'(rsp_valid), 64'd0);
    chk({tag, " timeout_end"}, 64'(rsp_timeout), 64'd0);
  endtask

  vec_t vecs[7];
  vec_t post_rst;

  initial begin
    logic [2:0] p_priv, p_ns, p_ins;
    p_priv = 3'(1 << PPROT_PRIV);
    p_ns   = 3'(1 << PPROT_NONSEC);
    p_ins  = 3'(1 << PPROT_INSTR);

    //         wr    addr          wdata         strb    prot          w  err  prdata        psel     pstrb   err  rdata
    vecs[0] = '{1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 4'b0101, p_ns,          0, 1'b0, 32'h0,        4'b0100, 4'b0101, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_1004, 32'h0,         4'b1111, p_priv,        3, 1'b0, 32'h1234_5678, 4'b0010, 4'b0000, 1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_3008, 32'h0,         4'b0000, p_priv | p_ns, 1, 1'b1, 32'hCAFE_F00D, 4'b1000, 4'b0000, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0102_0304, 4'b1000, 3'b000,        0, 1'b1, 32'h0,        4'b0001, 4'b1000, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'b0000, p_ins,         2, 1'b0, 32'h0BAD_C0DE, 4'b0001, 4'b0000, 1'b0, 32'h0BAD_C0DE};
    vecs[5] = '{1'b1, 32'h0000_3FFC, 32'hA1B2_C3D4, 4'b1111, 3'b111,        5, 1'b0, 32'h0,        4'b1000, 4'b1111, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'hFFFF_C004, 32'h0,         4'b0000, p_ins | p_ns,  0, 1'b0, 32'h55AA_55AA, 4'b0001, 4'b0000, 1'b0, 32'h55AA_55AA};
    post_rst = '{1'b0, 32'h0000_2004, 32'h0, 4'b0000, 3'b000, 1, 1'b0, 32'h7777_8888, 4'b0100, 4'b0000, 1'b0, 32'h7777_8888};

    req_valid = 1'b1; req_valid3 = 1'b0;
    req_write = 1'b1; req_addr = 32'h0000_2000; req_wdata = 32'hFFFF_FFFF;
    req_strb = '1; req_prot = 3'b111;
    bus_idle();

    // Reset values, with a request pending that must be ignored.
    repeat (2) step();
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst psel", 64'(psel), 64'd0);
    chk("rst penable", 64'(penable), 64'd0);
    chk("rst pwrite", 64'(pwrite), 64'd0);
    chk("rst paddr", 64'(paddr), 64'd0);
    chk("rst pwdata", 64'(pwdata), 64'd0);
    chk("rst pstrb", 64'(pstrb), 64'd0);
    chk("rst pprot", 64'(pprot), 64'd0);
    chk("rst rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Back-to-back: write slave 0, read slave 3 offered in the completion cycle.
    pslverr[0] = 1'b0; pslverr[3] = 1'b0;
    drive_req(1'b1, 32'h0000_0100, 32'h1111_2222, 4'b0011, 3'b000);
    step();
    req_valid = 1'b0;
    chk("b2b setup1_psel", 64'(psel), 64'h1);
    step();
    drive_req(1'b0, 32'h0000_3020, 32'h0, 4'b1111, p_ns);
    #1;
    chk("b2b cpl1_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    prdata[3*DW +: DW] = 32'hA5A5_0303;
    chk("b2b rsp1_valid", 64'(rsp_valid), 64'd1);
    chk("b2b rsp1_err", 64'(rsp_err), 64'd0);
    chk("b2b setup2_psel", 64'(psel), 64'h8);
    chk("b2b setup2_penable", 64'(penable), 64'd0);
    chk("b2b setup2_paddr", 64'(paddr), 64'h3020);
    chk("b2b setup2_pstrb", 64'(pstrb), 64'd0);
    chk("b2b setup2_pwdata", 64'(pwdata), 64'h1111_2222);
    step();
    chk("b2b acc2_penable", 64'(penable), 64'd1);
    chk("b2b acc2_rsp", 64'(rsp_valid), 64'd0);
    step();
    chk("b2b rsp2_valid", 64'(rsp_valid), 64'd1);
    chk("b2b rsp2_rdata", 64'(rsp_rdata), 64'hA5A5_0303);
    chk("b2b idle_psel", 64'(psel), 64'd0);
    exp_pwdata = 32'h1111_2222;
    bus_idle();
    step();

    // Decode error on the three-slave instance.
    req_write = 1'b0; req_addr = 32'h0000_3000; req_valid3 = 1'b1;
    #1;
    chk("dec ready_idle", 64'(req_ready3), 64'd1);
    step();
    req_valid3 = 1'b0;
    #1;
    chk("dec psel", 64'(psel3), 64'd0);
    chk("dec penable", 64'(penable3), 64'd0);
    chk("dec rsp_early", 64'(rsp_valid3), 64'd0);
    chk("dec ready_busy", 64'(req_ready3), 64'd0);
    step();
    chk("dec rsp_valid", 64'(rsp_valid3), 64'd1);
    chk("dec rsp_err", 64'(rsp_err3), 64'd1);
    chk("dec rsp_rdata", 64'(rsp_rdata3), 64'd0);
    chk("dec rsp_timeout", 64'(rsp_timeout3), 64'd0);
    chk("dec psel_after", 64'(psel3), 64'd0);
    chk("dec pstrb", 64'(pstrb3), 64'd0);
    step();
    chk("dec rsp_end", 64'(rsp_valid3), 64'd0);
    chk("dec ready_back", 64'(req_ready3), 64'd1);

    run_timeout(1'b0, "wdog");
    run_timeout(1'b1, "wdog_late");

    // Reset asserted mid-ACCESS.
    pready[2] = 1'b0;
    drive_req(1'b1, 32'h0000_2000, 32'h9999_AAAA, 4'b1111, 3'b000);
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rst_acc penable_before", 64'(penable), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_acc psel", 64'(psel), 64'd0);
    chk("rst_acc penable", 64'(penable), 64'd0);
    chk("rst_acc pstrb", 64'(pstrb), 64'd0);
    chk("rst_acc ready", 64'(req_ready), 64'd0);
    exp_pwdata = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_acc rsp%0d", k), 64'(rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    bus_idle();
    step();
    chk("rst_acc rsp_after", 64'(rsp_valid), 64'd0);
    chk("rst_acc psel_after", 64'(psel), 64'd0);
    run_vec(post_rst, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
